// File: rtl/de_regfile_sb.sv
// DE-side register file, CSR file and in-flight scoreboard fed by the writeback bus; optional WB_BYPASS_EN forwards same-cycle WB data.
// Latency: reads and stall_DE are combinational; writes and counter updates are visible the cycle after.
// Backpressure: stall_DE holds DE while a used source is busy; DE must not issue while it is high.
module de_regfile_sb #(
  parameter int NUM_REGS    = 32,
  parameter int SB_CNT_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [50:0] from_WB_to_DE,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        rs1_used,
  input  logic        rs2_used,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  input  logic [11:0] csr_rdno,
  output logic [31:0] csr_rdval,
  input  logic        issue_valid,
  input  logic        issue_wr_reg,
  input  logic [4:0]  issue_rd,
  output logic        stall_DE,
  output logic        sb_error
);

  typedef struct packed {
    logic        wr_reg;
    logic [4:0]  wregno;
    logic [31:0] regval;
    logic [11:0] wcsrno;
    logic        wr_csr;
  } wb_bus_t;

  localparam logic [SB_CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_BITS-1:0] CNT_ONE = SB_CNT_BITS'(1);

  wb_bus_t wb;
  assign wb = wb_bus_t'(from_WB_to_DE);

  logic [NUM_REGS-1:0][31:0]            regs;
  logic [NUM_REGS-1:0][SB_CNT_BITS-1:0] cnt;
  logic [3:0][31:0]                     csrs;
  logic [NUM_REGS-1:0]                  inc_v, dec_v, ovf, unf;
  logic                                 wb_reg_wr, sb_inc;
  logic [2:0]                           csr_wsel, csr_rsel;

  assign wb_reg_wr = wb.wr_reg && (wb.wregno != 5'd0);
  assign sb_inc    = issue_valid && issue_wr_reg && (issue_rd != 5'd0);

  // Returns {implemented, index}
  function automatic logic [2:0] csr_decode(input logic [11:0] addr);
    case (addr)
      12'h300: return 3'b100;
      12'h305: return 3'b101;
      12'h341: return 3'b110;
      12'h342: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  assign csr_wsel = csr_decode(wb.wcsrno);
  assign csr_rsel = csr_decode(csr_rdno);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (wb_reg_wr) begin
      regs[wb.wregno] <= wb.regval;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csrs <= '0;
    end else if (wb.wr_csr && csr_wsel[2]) begin
      csrs[csr_wsel[1:0]] <= wb.regval;
    end
  end

  // A matching issue and writeback on one register cancel; saturation flags an error instead of wrapping.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (sb_inc)    inc_v[issue_rd]  = 1'b1;
    if (wb_reg_wr) dec_v[wb.wregno] = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      ovf[r] = inc_v[r] && !dec_v[r] && (cnt[r] == CNT_MAX);
      unf[r] = dec_v[r] && !inc_v[r] && (cnt[r] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_v[r] && !dec_v[r] && !ovf[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_v[r] && !inc_v[r] && !unf[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (|ovf || |unf) begin
      sb_error <= 1'b1;
    end
  end

  function automatic logic busy(input logic [4:0] r);
`ifdef WB_BYPASS_EN
    return (cnt[r] > CNT_ONE) || ((cnt[r] == CNT_ONE) && !dec_v[r]);
`else
    return cnt[r] != '0;
`endif
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_reg_wr && (wb.wregno == r)) return wb.regval;
`endif
    return regs[r];
  endfunction

  always_comb begin
    rs1_val   = read_reg(rs1);
    rs2_val   = read_reg(rs2);
    stall_DE  = (rs1_used && busy(rs1)) || (rs2_used && busy(rs2));
    csr_rdval = 32'd0;
    if (csr_rsel[2]) begin
      csr_rdval = csrs[csr_rsel[1:0]];
`ifdef WB_BYPASS_EN
      if (wb.wr_csr && (wb.wcsrno == csr_rdno)) csr_rdval = wb.regval;
`endif
    end
  end

endmodule

// File: tb/tb_de_regfile_sb.sv
// Randomized bench for de_regfile_sb against a behavioural register/CSR/scoreboard model, plus directed literal checks.
module tb_de_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wr_reg, wr_csr;
  logic [4:0]  wregno;
  logic [31:0] regval;
  logic [11:0] wcsrno;
  logic [50:0] from_WB_to_DE;
  logic [4:0]  rs1, rs2, issue_rd;
  logic        rs1_used, rs2_used, issue_valid, issue_wr_reg;
  logic [11:0] csr_rdno;
  logic [31:0] rs1_val, rs2_val, csr_rdval;
  logic        stall_DE, sb_error;

  assign from_WB_to_DE = {wr_reg, wregno, regval, wcsrno, wr_csr};

  de_regfile_sb dut (
    .clk(clk), .reset(reset), .from_WB_to_DE(from_WB_to_DE),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .csr_rdno(csr_rdno), .csr_rdval(csr_rdval),
    .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .stall_DE(stall_DE), .sb_error(sb_error)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic [31:0] m_csr  [4096];
  bit          m_err;

  function automatic bit is_impl(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    if (BYP) return (m_cnt[r] > 1) || (m_cnt[r] == 1 && !(wr_reg && wregno == r));
    return m_cnt[r] != 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYP && wr_reg && wregno == r) return regval;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] exp_csr();
    if (!is_impl(csr_rdno)) return 32'd0;
    if (BYP && wr_csr && wcsrno == csr_rdno) return regval;
    return m_csr[csr_rdno];
  endfunction

  function automatic bit exp_stall();
    return (rs1_used && exp_busy(rs1)) || (rs2_used && exp_busy(rs2));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances at each posedge from the inputs presented in that cycle
  always @(posedge clk) begin : model
    int inc_r, dec_r;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      foreach (m_cnt[i])  m_cnt[i]  = 0;
      foreach (m_csr[i])  m_csr[i]  = 32'd0;
      m_err = 1'b0;
    end else begin
      if (wr_reg && wregno != 5'd0) m_regs[wregno] = regval;
      if (wr_csr && is_impl(wcsrno)) m_csr[wcsrno] = regval;
      inc_r = (issue_valid && issue_wr_reg && issue_rd != 5'd0) ? int'(issue_rd) : -1;
      dec_r = (wr_reg && wregno != 5'd0) ? int'(wregno) : -1;
      if (inc_r != dec_r) begin
        if (inc_r >= 0) begin
          if (m_cnt[inc_r] == 3) m_err = 1'b1;
          else m_cnt[inc_r]++;
        end
        if (dec_r >= 0) begin
          if (m_cnt[dec_r] == 0) m_err = 1'b1;
          else m_cnt[dec_r]--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rs1_val",   rs1_val,   exp_rd(rs1));
      check("rs2_val",   rs2_val,   exp_rd(rs2));
      check("csr_rdval", csr_rdval, exp_csr());
      check("stall_DE",  {31'd0, stall_DE}, {31'd0, exp_stall()});
      check("sb_error",  {31'd0, sb_error}, {31'd0, m_err});
    end
  end

  task automatic idle();
    reset = 0; wr_reg = 0; wregno = 0; regval = 0; wcsrno = 0; wr_csr = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; csr_rdno = 0;
    issue_valid = 0; issue_wr_reg = 0; issue_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = rd;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    idle(); wr_reg = 1; wregno = r; regval = v;
  endtask

  function automatic logic [11:0] pick_csr();
    case ($urandom_range(0, 4))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      3: return 12'h342;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic random_cycle();
    int start;
    idle();
    reset    = ($urandom_range(0, 299) == 0);
    rs1      = 5'($urandom); rs2 = 5'($urandom);
    rs1_used = 1'($urandom); rs2_used = 1'($urandom);
    csr_rdno = pick_csr();
    regval   = $urandom;
    wcsrno   = pick_csr();
    wr_csr   = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 1) == 1) begin
      start = $urandom_range(0, 31);
      for (int k = 0; k < 32; k++) begin
        if (!wr_reg && m_cnt[(start + k) % 32] > 0) begin
          wr_reg = 1; wregno = 5'((start + k) % 32);
        end
      end
    end
    if (!wr_reg && $urandom_range(0, 49) == 0) begin
      wr_reg = 1; wregno = 5'($urandom);
    end
    if ($urandom_range(0, 3) == 0) begin
      rs1 = wregno; rs1_used = 1;
    end
    issue_rd     = (wr_reg && $urandom_range(0, 7) == 0) ? wregno : 5'($urandom);
    issue_wr_reg = ($urandom_range(0, 3) != 0);
    issue_valid  = 1'($urandom) && !exp_stall() &&
                   (m_cnt[issue_rd] < 3 || $urandom_range(0, 39) == 0);
  endtask

  initial begin
    idle();
    // Reset while WB writes x5: the write must be lost
    reset = 1; wr_reg = 1; wregno = 5'd5; regval = 32'h1234;
    step();
    chk_en = 1'b1;
    step();
    idle(); rs1 = 5'd5; rs1_used = 1;
    @(negedge clk);
    check("reset_x5", rs1_val, 32'd0);
    check("reset_stall", {31'd0, stall_DE}, 32'd0);
    check("reset_sb_error", {31'd0, sb_error}, 32'd0);

    // Plain write of x7 (issued first so the WB has a writer to retire)
    issue(5'd7);
    step();
    wb_write(5'd7, 32'hDEADBEEF); rs1 = 5'd7; rs1_used = 1;
    @(negedge clk);
    check("x7_same_cycle", rs1_val, BYP ? 32'hDEADBEEF : 32'd0);
    step();
    idle(); rs1 = 5'd7; rs1_used = 1;
    @(negedge clk);
    check("x7_next_cycle", rs1_val, 32'hDEADBEEF);
    check("x7_no_stall", {31'd0, stall_DE}, 32'd0);

    // x0 write and issue are both ignored
    wb_write(5'd0, 32'hFFFFFFFF); issue_valid = 1; issue_wr_reg = 1; issue_rd = 5'd0;
    rs1 = 5'd0; rs1_used = 1;
    step();
    idle(); rs1 = 5'd0; rs1_used = 1;
    @(negedge clk);
    check("x0_read", rs1_val, 32'd0);
    check("x0_stall", {31'd0, stall_DE}, 32'd0);

    // Two writers to x3, retired one by one
    issue(5'd3); step();
    issue(5'd3); step();
    idle(); rs2 = 5'd3; rs2_used = 1;
    @(negedge clk);
    check("x3_cnt2_stall", {31'd0, stall_DE}, 32'd1);
    step();
    wb_write(5'd3, 32'h33); rs2 = 5'd3; rs2_used = 1;
    @(negedge clk);
    check("x3_wb1_stall", {31'd0, stall_DE}, 32'd1);
    step();
    wb_write(5'd3, 32'h34); rs2 = 5'd3; rs2_used = 1;
    @(negedge clk);
    check("x3_wb2_stall", {31'd0, stall_DE}, BYP ? 32'd0 : 32'd1);
    step();
    idle(); rs2 = 5'd3; rs2_used = 1;
    @(negedge clk);
    check("x3_after_stall", {31'd0, stall_DE}, 32'd0);
    check("x3_value", rs2_val, 32'h34);

    // Issue and WB to x4 in one cycle with cnt=1 leave it busy
    issue(5'd4); step();
    wb_write(5'd4, 32'h44); issue_valid = 1; issue_wr_reg = 1; issue_rd = 5'd4;
    step();
    idle(); rs1 = 5'd4; rs1_used = 1;
    @(negedge clk);
    check("x4_still_busy", {31'd0, stall_DE}, 32'd1);
    check("x4_no_error", {31'd0, sb_error}, 32'd0);
    step();
    wb_write(5'd4, 32'h45); step();

    // CSR file
    idle(); wr_csr = 1; wcsrno = 12'h305; regval = 32'h80; csr_rdno = 12'h305;
    step();
    idle(); csr_rdno = 12'h305;
    @(negedge clk);
    check("mtvec", csr_rdval, 32'h80);
    idle(); wr_csr = 1; wcsrno = 12'h123; regval = 32'h55; csr_rdno = 12'h123;
    step();
    idle(); csr_rdno = 12'h123;
    @(negedge clk);
    check("csr_unimpl", csr_rdval, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      random_cycle();
      step();
    end

    // Underflow on x9, then sticky
    idle(); reset = 1; step();
    wb_write(5'd9, 32'h9); step();
    idle();
    @(negedge clk);
    check("underflow", {31'd0, sb_error}, 32'd1);
    repeat (3) step();
    @(negedge clk);
    check("underflow_sticky", {31'd0, sb_error}, 32'd1);

    // Fourth writer to x10 overflows
    idle(); reset = 1; step();
    for (int k = 0; k < 3; k++) begin
      issue(5'd10); step();
    end
    idle();
    @(negedge clk);
    check("cnt3_no_error", {31'd0, sb_error}, 32'd0);
    issue(5'd10); step();
    idle();
    @(negedge clk);
    check("overflow", {31'd0, sb_error}, 32'd1);

    idle(); reset = 1; step();
    idle(); rs1 = 5'd10; rs1_used = 1;
    @(negedge clk);
    check("final_stall", {31'd0, stall_DE}, 32'd0);
    check("final_sb_error", {31'd0, sb_error}, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
